// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched {ir, pc} entries with synchronous clear
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generation, credit-limited imem requests and decode-side fetch buffer
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;

    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_accept;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_aligned;
    logic          unused_pc_lsb;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb    = ^redirect_pc[1:0];

    // Buffered plus outstanding words never exceed DEPTH, so every response has a slot.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign imem_req_valid = RST_N && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_accept = imem_rsp_valid && (inflight_q != '0);
    assign rsp_drop   = rsp_accept && (drop_cnt_q != '0);
    assign push       = rsp_accept && !rsp_drop && !redirect_valid;
    assign push_entry = '{ir: imem_rsp_data, pc: rsp_pc_q};

    assign id_valid = !fifo_empty && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign id_ir    = fifo_empty ? NOP_INSTR : fifo_head.ir;
    assign id_pc    = fifo_empty ? 32'h0000_0000 : fifo_head.pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_accept);
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            drop_cnt_d = inflight_q - CW'(rsp_accept);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
            if (push)     rsp_pc_d   = rsp_pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RST_N),
        .clear_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    rsp_without_request: assert property (@(posedge CLK) disable iff (!RST_N)
        !(imem_rsp_valid && inflight_q == '0));

    push_into_full: assert property (@(posedge CLK) disable iff (!RST_N)
        !(push && fifo_full && !pop));

endmodule
